sram_like_port_arbiter: RTL

- Shares the single SRAM-like data memory port between two requesters: instruction fetch (master 0) and the load/store unit (master 1).
- The load/store side is the one that feeds the load-result formatting stage.
- The block arbitrates address phases and locks a grant until `addr_ok`.
- It records the owner of each accepted request in an in-order ID FIFO, and uses that FIFO to route each `data_ok`/`rdata` back to the correct requester.

---
 rtl/sram_like_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sram_like_port_arbiter.sv
// ============================================================================
// Module      : sram_like_port_arbiter
// Description : Shares one SRAM-like memory port between instruction fetch
//               (master 0) and the load/store unit (master 1). Address phases
//               are arbitrated with a grant lock held until addr_ok; accepted
//               request owners are kept in an in-order ID FIFO that steers
//               each data_ok/rdata back to its requester.
//               Optional macro ARB_ROUND_ROBIN_EN: alternate the grant between
//               masters when both request with no lock (default: data wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic              clk,
    input  logic              resetn,
    // master 0: instruction fetch
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [31:0]       inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    // master 1: load/store unit
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    // shared slave port
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    // debug / performance
    output logic [CNT_W-1:0]  outstanding
);

    localparam int               c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(MAX_OUTSTANDING);

    // grant lock and ID FIFO state
    logic                       r_lock_vld;
    logic                       r_lock_id;
    logic [MAX_OUTSTANDING-1:0] r_id_fifo;
    logic [c_PTR_W-1:0]         r_wptr;
    logic [c_PTR_W-1:0]         r_rptr;
    logic [CNT_W-1:0]           r_count;

    logic w_full;
    logic w_empty;
    logic w_pref;        // master preferred when both request without a lock
    logic w_grant_id;
    logic w_grant_vld;
    logic w_mem_req;
    logic w_push;
    logic w_pop;
    logic w_head_id;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_head_id = r_id_fifo[r_rptr];

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_ptr;

    // After each acceptance, prefer the master that did not just win
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr <= 1'b1;
        end else if (w_push) begin
            r_rr_ptr <= ~w_grant_id;
        end
    end

    assign w_pref = r_rr_ptr;
`else
    assign w_pref = 1'b1;
`endif

    // Select the granted master: a held lock overrides fresh arbitration
    always_comb begin
        w_grant_id  = 1'b0;
        w_grant_vld = 1'b0;
        if (r_lock_vld) begin
            w_grant_id  = r_lock_id;
            w_grant_vld = r_lock_id ? data_req : inst_req;
        end else if (data_req && inst_req) begin
            w_grant_id  = w_pref;
            w_grant_vld = 1'b1;
        end else if (data_req) begin
            w_grant_id  = 1'b1;
            w_grant_vld = 1'b1;
        end else if (inst_req) begin
            w_grant_id  = 1'b0;
            w_grant_vld = 1'b1;
        end
    end

    // A full FIFO blocks new requests; reset forces every output low
    assign w_mem_req = resetn & w_grant_vld & ~w_full;
    assign w_push    = w_mem_req & mem_addr_ok;
    assign w_pop     = resetn & mem_data_ok & ~w_empty;

    assign mem_req      = w_mem_req;
    assign inst_addr_ok = w_push & ~w_grant_id;
    assign data_addr_ok = w_push &  w_grant_id;
    assign inst_data_ok = w_pop  & ~w_head_id;
    assign data_data_ok = w_pop  &  w_head_id;
    assign inst_rdata   = resetn ? mem_rdata : 32'h0;
    assign data_rdata   = resetn ? mem_rdata : 32'h0;
    assign outstanding  = r_count;

    // Route the granted master's command fields onto the slave port
    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (w_mem_req) begin
            if (w_grant_id) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    // Hold the grant while the slave stalls; drop it on accept or if the owner withdraws
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
        end else if (w_push) begin
            r_lock_vld <= 1'b0;
        end else if (w_mem_req) begin
            r_lock_vld <= 1'b1;
            r_lock_id  <= w_grant_id;
        end else if (r_lock_vld && !w_grant_vld) begin
            r_lock_vld <= 1'b0;
        end
    end

    // In-order owner FIFO: push on accept, pop on response; pop sees the old head
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_id_fifo <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_id_fifo[r_wptr] <= w_grant_id;
                r_wptr            <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire
